rl11q: RTL and testbench



---
 rtl/rl11q.sv | 206 ++++++++++++++++++++
 tb/tb_rl11q.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rl11q.sv
// rl11q: RL11 CS/BA/DA/MP Unibus register block for up to 4 drives. Each PDP GO is
// snapshotted into a QDEPTH-deep command queue drained by the ARM. Define RL11Q_ARMIRQ_EN for armirq.
module rl11q #(
  parameter logic [17:0] ADDR   = 18'o774400,
  parameter logic [7:0]  INTVEC = 8'o160,
  parameter int          NDRV   = 4,
  parameter int          QDEPTH = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armraddr,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  output logic        armirq,
  output logic        intreq,
  output logic [7:0]  intvec,
  input  logic [17:0] a_in_h,
  input  logic [1:0]  c_in_h,
  input  logic [15:0] d_in_h,
  input  logic        init_in_h,
  input  logic        msyn_in_h,
  output logic [15:0] d_out_h,
  output logic        ssyn_out_h
);
  localparam int          PW      = $clog2(QDEPTH);
  localparam logic [4:0]  QFULL   = 5'(QDEPTH);
  localparam logic [31:0] IDENT   = 32'h524C3002;
  localparam logic [13:1] CS_INIT = 13'b0000001000000;

  logic [13:1]   cs_q, cs_d;
  logic [15:1]   ba_q, ba_d;
  logic [15:0]   da_q, da_d, mp_q, mp_d, hda_q, hda_d, crc_q, crc_d;
  logic [1:0]    mpmux_q, mpmux_d;
  logic          enable_q, enable_d, ovf_q, ovf_d;
  logic [3:0]    derr_q, derr_d, drdy_q, drdy_d;
  logic [4:0]    count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [15:0]   dout_q, dout_d;
  logic          ssyn_q, ssyn_d, armirq_q, armirq_d;
  logic [63:0]   mem_q [QDEPTH];
  logic          push;
  logic [63:0]   push_data, head;
  logic [3:0]    absent;
  logic [15:0]   cs_live, cur_reg, merged;
  logic          bus_hit, lane_lo, lane_hi;
  logic [1:0]    rsel;

  // Full 16-bit CS view: stored bits [13:1] plus the live DRDY/DE/CE status bits.
  function automatic logic [15:0] cs_view(input logic [13:1] c, input logic [3:0] rdy,
                                          input logic [3:0] err, input logic [3:0] abs_i);
    logic de;
    de = err[c[9:8]] | abs_i[c[9:8]];
    return {de | (|c[13:10]), de, c, rdy[c[9:8]]};
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) absent[i] = (i >= NDRV);
  end

  assign cs_live = cs_view(cs_q, drdy_q, derr_q, absent);
  assign head    = (count_q != 5'd0) ? mem_q[rptr_q] : 64'b0;
  assign rsel    = a_in_h[2:1];
  assign lane_lo = ~c_in_h[0] | ~a_in_h[0];
  assign lane_hi = ~c_in_h[0] | a_in_h[0];
  assign bus_hit = enable_q & msyn_in_h & ~ssyn_q & (a_in_h[17:3] == ADDR[17:3]);

  always_comb begin
    case (rsel)
      2'd0:    cur_reg = cs_live;
      2'd1:    cur_reg = {ba_q, 1'b0};
      2'd2:    cur_reg = da_q;
      default: cur_reg = mp_q;
    endcase
    merged = {lane_hi ? d_in_h[15:8] : cur_reg[15:8], lane_lo ? d_in_h[7:0] : cur_reg[7:0]};
  end

  always_comb begin
    cs_d = cs_q;  ba_d = ba_q;  da_d = da_q;  mp_d = mp_q;
    hda_d = hda_q;  crc_d = crc_q;  mpmux_d = mpmux_q;
    enable_d = enable_q;  ovf_d = ovf_q;  derr_d = derr_q;  drdy_d = drdy_q;
    count_d = count_q;  wptr_d = wptr_q;  rptr_d = rptr_q;
    dout_d = dout_q;  ssyn_d = ssyn_q;
    push = 1'b0;
    push_data = 64'b0;
`ifdef RL11Q_ARMIRQ_EN
    armirq_d = (count_q != 5'd0) | ovf_q;
`else
    armirq_d = 1'b0;
`endif

    if (!msyn_in_h) begin
      dout_d = 16'b0;
      ssyn_d = 1'b0;
    end

    // An ARM write steals the bus slot; MSYN is still held so the bus cycle retries.
    if (armwrite) begin
      case (armwaddr)
        3'd1: begin
          ba_d = armwdata[31:17];
          cs_d = armwdata[13:1];
        end
        3'd2: begin
          mp_d = armwdata[31:16];
          da_d = armwdata[15:0];
        end
        3'd3: begin
          crc_d = armwdata[31:16];
          hda_d = armwdata[15:0];
        end
        3'd4: begin
          mpmux_d = armwdata[9:8];
          derr_d  = armwdata[7:4];
          drdy_d  = armwdata[3:0];
          if (armwdata[16]) ovf_d = 1'b0;
        end
        3'd5: enable_d = armwdata[31];
        3'd6: begin
          if (count_q != 5'd0) begin
            rptr_d  = rptr_q + PW'(1);
            count_d = count_q - 5'd1;
          end
        end
        default: ;
      endcase
    end else if (bus_hit) begin
      ssyn_d = 1'b1;
      dout_d = 16'b0;
      if (c_in_h[1]) begin
        case (rsel)
          2'd0: begin
            cs_d[9:1] = merged[9:1];
            if (lane_lo && !d_in_h[7]) begin
              if (count_q != QFULL) begin
                push      = 1'b1;
                push_data = {ba_q, 1'b0, cs_view(cs_d, drdy_q, derr_q, absent), mp_q, da_q};
                wptr_d    = wptr_q + PW'(1);
                count_d   = count_q + 5'd1;
              end else begin
                ovf_d     = 1'b1;
                cs_d[10]  = 1'b1;
              end
            end
          end
          2'd1:    ba_d = merged[15:1];
          2'd2:    da_d = merged;
          default: mp_d = merged;
        endcase
      end else begin
        case (rsel)
          2'd0: dout_d = cs_live;
          2'd1: dout_d = {ba_q, 1'b0};
          2'd2: dout_d = da_q;
          default: begin
            case (mpmux_q)
              2'd0: dout_d = mp_q;
              2'd1: begin dout_d = hda_q; mpmux_d = 2'd2; end
              2'd2: begin dout_d = 16'b0; mpmux_d = 2'd3; end
              default: begin dout_d = crc_q; mpmux_d = 2'd0; end
            endcase
          end
        endcase
      end
    end

    if (RESET || init_in_h) begin
      cs_d = CS_INIT;  ba_d = 15'b0;  da_d = 16'b0;  mpmux_d = 2'd0;
      count_d = 5'd0;  wptr_d = '0;  rptr_d = '0;
      dout_d = 16'b0;  ssyn_d = 1'b0;  push = 1'b0;
    end
    if (RESET) begin
      enable_d = 1'b0;  derr_d = 4'b0;  drdy_d = 4'b0;  ovf_d = 1'b0;
      mp_d = 16'b0;  hda_d = 16'b0;  crc_d = 16'b0;  armirq_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    cs_q <= cs_d;  ba_q <= ba_d;  da_q <= da_d;  mp_q <= mp_d;
    hda_q <= hda_d;  crc_q <= crc_d;  mpmux_q <= mpmux_d;
    enable_q <= enable_d;  ovf_q <= ovf_d;  derr_q <= derr_d;  drdy_q <= drdy_d;
    count_q <= count_d;  wptr_q <= wptr_d;  rptr_q <= rptr_d;
    dout_q <= dout_d;  ssyn_q <= ssyn_d;  armirq_q <= armirq_d;
    if (push) mem_q[wptr_q] <= push_data;
  end

  always_comb begin
    case (armraddr)
      3'd0:    armrdata = IDENT;
      3'd1:    armrdata = {ba_q, 1'b0, cs_live};
      3'd2:    armrdata = {mp_q, da_q};
      3'd3:    armrdata = {crc_q, hda_q};
      3'd4:    armrdata = {15'b0, ovf_q, 1'b0, count_q, mpmux_q, derr_q, drdy_q};
      3'd5:    armrdata = {enable_q, 5'b0, INTVEC, ADDR};
      3'd6:    armrdata = head[63:32];
      default: armrdata = head[31:0];
    endcase
  end

  assign intreq     = cs_q[6] & cs_q[7];
  assign intvec     = {INTVEC[7:2], 2'b00};
  assign armirq     = armirq_q;
  assign d_out_h    = dout_q;
  assign ssyn_out_h = ssyn_q;
endmodule

// File: tb/tb_rl11q.sv
// Bench for rl11q (NDRV=2, QDEPTH=4): vector table, directed corner sequences and a
// randomized run checked against a queue-based register model.
module tb_rl11q;
  localparam logic [17:0] ADDR   = 18'o774400;
  localparam logic [7:0]  INTVEC = 8'o160;
  localparam int          NDRV   = 2;
  localparam int          QDEPTH = 4;
`ifdef RL11Q_ARMIRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        CLOCK, RESET, armwrite, armirq, intreq, init_in_h, msyn_in_h, ssyn_out_h;
  logic [2:0]  armraddr, armwaddr;
  logic [31:0] armwdata, armrdata;
  logic [7:0]  intvec;
  logic [17:0] a_in_h;
  logic [1:0]  c_in_h;
  logic [15:0] d_in_h, d_out_h;

  rl11q #(.ADDR(ADDR), .INTVEC(INTVEC), .NDRV(NDRV), .QDEPTH(QDEPTH)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .armwrite(armwrite), .armraddr(armraddr),
    .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata), .armirq(armirq),
    .intreq(intreq), .intvec(intvec), .a_in_h(a_in_h), .c_in_h(c_in_h), .d_in_h(d_in_h),
    .init_in_h(init_in_h), .msyn_in_h(msyn_in_h), .d_out_h(d_out_h), .ssyn_out_h(ssyn_out_h)
  );

  // ---------------- clock ----------------
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_cs, m_ba, m_da, m_mp, m_hda, m_crc;
  logic [1:0]  m_mpmux;
  logic [3:0]  m_drdy, m_derr;
  logic        m_ovf;
  logic [63:0] exp_q[$];

  function automatic logic [15:0] m_cs_live();
    logic [1:0] ds;
    logic [15:0] v;
    logic de;
    ds = m_cs[9:8];
    de = m_derr[ds] || (int'(ds) >= NDRV);
    v = m_cs & 16'h3FFE;
    v[0] = m_drdy[ds];
    v[14] = de;
    v[15] = de || (m_cs[13:10] != 4'd0);
    return v;
  endfunction

  function automatic void m_reset();
    m_cs = 16'o200; m_ba = 0; m_da = 0; m_mp = 0; m_hda = 0; m_crc = 0;
    m_mpmux = 0; m_drdy = 0; m_derr = 0; m_ovf = 0;
    exp_q.delete();
  endfunction

  function automatic void m_bus_write(input logic [1:0] sel, input logic byte_, input logic a0,
                                      input logic [15:0] d);
    logic lo, hi;
    logic [15:0] cur, nv;
    lo = !byte_ || !a0;
    hi = !byte_ || a0;
    case (sel)
      2'd0: cur = m_cs_live();
      2'd1: cur = m_ba;
      2'd2: cur = m_da;
      default: cur = m_mp;
    endcase
    nv = cur;
    if (lo) nv[7:0] = d[7:0];
    if (hi) nv[15:8] = d[15:8];
    case (sel)
      2'd0: begin
        m_cs[9:1] = nv[9:1];
        if (lo && !d[7]) begin
          if (exp_q.size() < QDEPTH) exp_q.push_back({m_ba, m_cs_live(), m_mp, m_da});
          else begin m_ovf = 1'b1; m_cs[10] = 1'b1; end
        end
      end
      2'd1: m_ba = nv & 16'hFFFE;
      2'd2: m_da = nv;
      default: m_mp = nv;
    endcase
  endfunction

  function automatic logic [15:0] m_bus_read(input logic [1:0] sel);
    logic [15:0] v;
    case (sel)
      2'd0: v = m_cs_live();
      2'd1: v = m_ba;
      2'd2: v = m_da;
      default: begin
        case (m_mpmux)
          2'd0: v = m_mp;
          2'd1: v = m_hda;
          2'd2: v = 16'h0;
          default: v = m_crc;
        endcase
        if (m_mpmux != 2'd0) m_mpmux = m_mpmux + 2'd1;
      end
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_arm_read(input logic [2:0] a);
    case (a)
      3'd1: return {m_ba, m_cs_live()};
      3'd2: return {m_mp, m_da};
      3'd4: return {15'b0, m_ovf, 1'b0, 5'(exp_q.size()), m_mpmux, m_derr, m_drdy};
      3'd6: return (exp_q.size() != 0) ? exp_q[0][63:32] : 32'h0;
      3'd7: return (exp_q.size() != 0) ? exp_q[0][31:0] : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge CLOCK); #1;
  endtask

  task automatic arm_wr(input logic [2:0] a, input logic [31:0] d);
    armwrite = 1'b1; armwaddr = a; armwdata = d;
    tick();
    armwrite = 1'b0;
  endtask

  task automatic arm_rd(input logic [2:0] a, output logic [31:0] d);
    armraddr = a;
    @(negedge CLOCK);
    d = armrdata;
  endtask

  task automatic bus_xfer(input logic [1:0] sel, input logic wr, input logic byte_,
                          input logic a0, input logic [15:0] data,
                          output logic [15:0] rdata, output int lat);
    a_in_h = ADDR + 18'({sel, a0});
    c_in_h = {wr, byte_};
    d_in_h = data;
    msyn_in_h = 1'b1;
    lat = 0;
    while (ssyn_out_h !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("ssyn_wait", 32'(ssyn_out_h), 32'd1);
    rdata = d_out_h;
    msyn_in_h = 1'b0;
    tick();
  endtask

  task automatic bus_wr(input logic [1:0] sel, input logic [15:0] d);
    logic [15:0] r;
    int lat;
    bus_xfer(sel, 1'b1, 1'b0, 1'b0, d, r, lat);
  endtask

  task automatic bus_rd(input logic [1:0] sel, output logic [15:0] r);
    int lat;
    bus_xfer(sel, 1'b0, 1'b0, 1'b0, 16'h0, r, lat);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  sel;
    logic        byte_;
    logic        a0;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[11];

  initial begin
    logic [31:0] r32;
    logic [15:0] r16;
    int lat;

    tbl[0]  = '{2'd1, 1'b0, 1'b0, 16'o1000, 16'o1000};
    tbl[1]  = '{2'd1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFE};
    tbl[2]  = '{2'd1, 1'b1, 1'b0, 16'h1234, 16'hFF34};
    tbl[3]  = '{2'd1, 1'b1, 1'b1, 16'hAB00, 16'hAB34};
    tbl[4]  = '{2'd2, 1'b0, 1'b0, 16'o123,  16'o123};
    tbl[5]  = '{2'd2, 1'b1, 1'b1, 16'h5500, 16'h5553};
    tbl[6]  = '{2'd3, 1'b0, 1'b0, 16'h0F0F, 16'h0F0F};
    tbl[7]  = '{2'd3, 1'b1, 1'b0, 16'h00AA, 16'h0FAA};
    tbl[8]  = '{2'd0, 1'b0, 1'b0, 16'o340,  16'o340};
    tbl[9]  = '{2'd0, 1'b1, 1'b1, 16'h0300, 16'hC3E0};
    tbl[10] = '{2'd0, 1'b1, 1'b0, 16'h00FF, 16'hC3FE};

    RESET = 1'b1; armwrite = 0; armraddr = 0; armwaddr = 0; armwdata = 0;
    a_in_h = 0; c_in_h = 0; d_in_h = 0; init_in_h = 0; msyn_in_h = 0;
    repeat (3) tick();
    RESET = 1'b0;

    // Reset state
    chk("rst_armirq", 32'(armirq), 32'd0);
    chk("rst_intreq", 32'(intreq), 32'd0);
    chk("rst_dout", 32'(d_out_h), 32'd0);
    chk("rst_ssyn", 32'(ssyn_out_h), 32'd0);
    chk("intvec", 32'(intvec), 32'(8'o160));
    arm_rd(3'd0, r32); chk("ident", r32, 32'h524C3002);
    arm_rd(3'd4, r32); chk("rst_reg4", r32, 32'h0);
    arm_rd(3'd5, r32); chk("reg5_off", r32, {1'b0, 5'b0, 8'o160, 18'o774400});
    arm_wr(3'd5, 32'h8000_0000);
    arm_rd(3'd5, r32); chk("reg5_on", r32, {1'b1, 5'b0, 8'o160, 18'o774400});
    bus_xfer(2'd0, 1'b0, 1'b0, 1'b0, 16'h0, r16, lat);
    chk("rst_cs", 32'(r16), 32'(16'o200));
    chk("ssyn_latency", 32'(lat), 32'd1);

    // Table of bus write / read-back vectors
    foreach (tbl[i]) begin
      bus_xfer(tbl[i].sel, 1'b1, tbl[i].byte_, tbl[i].a0, tbl[i].wdata, r16, lat);
      bus_rd(tbl[i].sel, r16);
      chk($sformatf("tbl%0d", i), 32'(r16), 32'(tbl[i].exp));
    end
    arm_rd(3'd4, r32); chk("tbl_nopush", r32, 32'h0);
    arm_wr(3'd1, {16'o0, 16'o200});
    arm_wr(3'd2, 32'h0);

    // First GO
    bus_wr(2'd1, 16'o1000);
    bus_wr(2'd2, 16'o123);
    bus_wr(2'd0, 16'o14);
    arm_rd(3'd4, r32); chk("go_count", (r32 >> 10) & 32'h1F, 32'd1);
    arm_rd(3'd6, r32); chk("go_head_hi", r32, {16'o1000, 16'o14});
    arm_rd(3'd7, r32); chk("go_head_lo", r32, {16'h0, 16'o123});
    bus_rd(2'd0, r16); chk("go_cs", 32'(r16), 32'(16'o14));
    tick();
    chk("go_armirq", 32'(armirq), 32'(IRQ_EN));

    // Fill and overflow
    repeat (4) bus_wr(2'd0, 16'o14);
    arm_rd(3'd4, r32); chk("ovf_reg4", r32, 32'h0001_1000);
    bus_rd(2'd0, r16); chk("ovf_cs", 32'(r16), 32'h840C);
    arm_wr(3'd4, 32'h0001_0000);
    arm_rd(3'd4, r32); chk("ovf_clear", r32, 32'h0000_1000);

    // Drain, then pop on empty
    for (int i = 0; i < 4; i++) begin
      arm_rd(3'd6, r32); chk($sformatf("drain_hi%0d", i), r32, {16'o1000, 16'o14});
      arm_rd(3'd7, r32); chk($sformatf("drain_lo%0d", i), r32, {16'h0, 16'o123});
      arm_wr(3'd6, 32'h0);
    end
    arm_wr(3'd6, 32'h0);
    arm_rd(3'd4, r32); chk("empty_reg4", r32, 32'h0);
    arm_rd(3'd6, r32); chk("empty_hi", r32, 32'h0);
    arm_rd(3'd7, r32); chk("empty_lo", r32, 32'h0);
    arm_wr(3'd1, {16'o1000, 16'o200});
    bus_wr(2'd0, 16'o24);
    arm_rd(3'd4, r32); chk("after_underpop_cnt", r32, 32'h0000_0400);
    arm_rd(3'd6, r32); chk("after_underpop_hd", r32, {16'o1000, 16'o24});
    arm_wr(3'd6, 32'h0);
    tick();
    chk("drained_armirq", 32'(armirq), 32'd0);

    // MP multiplexer sequence
    arm_wr(3'd3, {16'o55, 16'o7});
    arm_wr(3'd2, {16'o4321, 16'o123});
    arm_wr(3'd4, 32'h0000_0100);
    arm_rd(3'd4, r32); chk("mpmux_set", r32, 32'h0000_0100);
    bus_rd(2'd3, r16); chk("mp_hda", 32'(r16), 32'(16'o7));
    bus_rd(2'd3, r16); chk("mp_zero", 32'(r16), 32'h0);
    bus_rd(2'd3, r16); chk("mp_crc", 32'(r16), 32'(16'o55));
    bus_rd(2'd3, r16); chk("mp_plain", 32'(r16), 32'(16'o4321));
    arm_rd(3'd4, r32); chk("mpmux_back", r32, 32'h0);

    // Absent drive and interrupt request
    arm_wr(3'd4, 32'h0000_0008);
    bus_wr(2'd0, 16'o1600);
    bus_rd(2'd0, r16); chk("ds3_rdy", 32'(r16), 32'hC381);
    arm_wr(3'd4, 32'h0);
    bus_rd(2'd0, r16); chk("ds3_notrdy", 32'(r16), 32'hC380);
    chk("intreq_off", 32'(intreq), 32'd0);
    bus_wr(2'd0, 16'o300);
    chk("intreq_on", 32'(intreq), 32'd1);
    arm_rd(3'd1, r32); chk("reg1_ie", r32, {16'o1000, 16'o300});

    // INIT with commands queued
    bus_wr(2'd0, 16'o14);
    bus_wr(2'd0, 16'o14);
    arm_rd(3'd4, r32); chk("pre_init_cnt", r32, 32'h0000_0800);
    init_in_h = 1'b1; tick(); init_in_h = 1'b0;
    arm_rd(3'd4, r32); chk("init_reg4", r32, 32'h0);
    arm_rd(3'd1, r32); chk("init_reg1", r32, {16'h0, 16'o200});
    arm_rd(3'd6, r32); chk("init_head", r32, 32'h0);
    bus_rd(2'd0, r16); chk("init_cs", 32'(r16), 32'(16'o200));

    // Randomized run against the model
    RESET = 1'b1; tick(); tick(); RESET = 1'b0;
    m_reset();
    arm_wr(3'd5, 32'h8000_0000);
    r32 = $urandom;
    arm_wr(3'd3, r32);
    m_crc = r32[31:16]; m_hda = r32[15:0];
    for (int it = 0; it < 400; it++) begin
      int op;
      logic [1:0] sel;
      logic byte_, a0;
      logic [15:0] d;
      logic [31:0] w;
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        sel = (op <= 1) ? 2'd0 : 2'($urandom_range(0, 3));
        d = 16'($urandom);
        if (sel == 2'd0 && $urandom_range(0, 3) != 0) d[7] = 1'b0;
        byte_ = 1'($urandom_range(0, 1));
        a0 = byte_ ? 1'($urandom_range(0, 1)) : 1'b0;
        m_bus_write(sel, byte_, a0, d);
        bus_xfer(sel, 1'b1, byte_, a0, d, r16, lat);
      end else if (op <= 5) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        arm_wr(3'd6, 32'h0);
      end else if (op == 6) begin
        w = $urandom;
        m_ba = w[31:16] & 16'hFFFE;
        m_cs[13:1] = w[13:1];
        arm_wr(3'd1, w);
      end else if (op == 7) begin
        w = $urandom;
        m_mpmux = w[9:8]; m_derr = w[7:4]; m_drdy = w[3:0];
        if (w[16]) m_ovf = 1'b0;
        arm_wr(3'd4, w);
      end else if (op == 8) begin
        sel = 2'($urandom_range(0, 3));
        bus_rd(sel, r16);
        chk($sformatf("rnd_bus_rd%0d", sel), 32'(r16), 32'(m_bus_read(sel)));
      end else begin
        arm_rd(3'd1, r32); chk("rnd_reg1", r32, m_arm_read(3'd1));
        arm_rd(3'd2, r32); chk("rnd_reg2", r32, m_arm_read(3'd2));
        arm_rd(3'd4, r32); chk("rnd_reg4", r32, m_arm_read(3'd4));
        arm_rd(3'd6, r32); chk("rnd_reg6", r32, m_arm_read(3'd6));
        arm_rd(3'd7, r32); chk("rnd_reg7", r32, m_arm_read(3'd7));
      end
      tick();
      chk("rnd_armirq", 32'(armirq), 32'(IRQ_EN & ((exp_q.size() != 0) | m_ovf)));
      chk("rnd_intreq", 32'(intreq), 32'(m_cs[6] & m_cs[7]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
